// File: rtl/wwd_display_driver.sv
// wwd_display_driver
//   Captures words written by the CPU WWD instruction, keeps a 4-deep history
//   and scans the selected word onto a 4-digit multiplexed 7-segment display.
//
// Ports
//   clk        : system clock (shared with the CPU)
//   reset_cpu  : synchronous active-high reset
//   data_in    : CPU output_port word
//   data_valid : one-cycle strobe qualifying data_in
//   pc_in      : CPU PC low byte, mirrored on led one cycle later
//   hold       : freeze capture, history and capture counter
//   show_hist  : 1 = display history entry, 0 = display live capture
//   hist_sel   : history index, 0 = most recent, 3 = oldest
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   an         : digit enables, active-low, an[0] = rightmost digit
//   led        : registered pc_in
//   wwd_count  : accepted captures, saturating at 255
module wwd_display_driver #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_cpu,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic [7:0]  pc_in,
    input  logic        hold,
    input  logic        show_hist,
    input  logic [1:0]  hist_sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [7:0]  led,
    output logic [7:0]  wwd_count
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic [15:0]       cap_q, cap_d;
    logic [3:0][15:0]  hist_q, hist_d;
    logic [1:0]        wptr_q, wptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        led_q;

    logic              accept;
    logic [1:0]        rd_idx;
    logic [15:0]       disp;
    logic [3:0]        nib;

    assign accept = data_valid & ~hold;
    // Write pointer sits one past the newest entry; 2-bit arithmetic wraps mod 4.
    assign rd_idx = wptr_q - 2'd1 - hist_sel;
    assign disp   = show_hist ? hist_q[rd_idx] : cap_q;
    assign nib    = disp[{idx_q, 2'b00} +: 4];

    always_comb begin
        cap_d  = cap_q;
        hist_d = hist_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        idx_d  = idx_q;

        if (accept) begin
            cap_d          = data_in;
            hist_d[wptr_q] = data_in;
            wptr_d         = wptr_q + 2'd1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end

        // Digit index advances on the same edge the divider wraps.
        if (div_q == DIV_MAX) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Display outputs reflect the current index/word, registered next edge.
        an_d  = ~(4'b0001 << idx_q);
        seg_d = hex7(nib);
        dp_d  = ~(show_hist && (idx_q == 2'd0));
    end

    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            cap_q  <= '0;
            hist_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            div_q  <= '0;
            idx_q  <= '0;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
            an_q   <= 4'b1111;
            led_q  <= '0;
        end else begin
            cap_q  <= cap_d;
            hist_q <= hist_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            led_q  <= pc_in;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign led       = led_q;
    assign wwd_count = cnt_q;

endmodule

// File: tb/tb_wwd_display_driver.sv
module tb_wwd_display_driver;

    logic        clk = 1'b0;
    logic        reset_cpu;
    logic [15:0] data_in;
    logic        data_valid;
    logic [7:0]  pc_in;
    logic        hold;
    logic        show_hist;
    logic [1:0]  hist_sel;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [7:0]  led;
    logic [7:0]  wwd_count;

    wwd_display_driver #(.SCAN_DIV(4)) dut (
        .clk(clk), .reset_cpu(reset_cpu), .data_in(data_in), .data_valid(data_valid),
        .pc_in(pc_in), .hold(hold), .show_hist(show_hist), .hist_sel(hist_sel),
        .seg(seg), .dp(dp), .an(an), .led(led), .wwd_count(wwd_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] led_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;

    logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Align to the first cycle of a digit-0 slot (an just changed to 1110).
    task automatic wait_digit0();
        logic [3:0] prev;
        bit found;
        prev = an;
        found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            tick();
            if (an === 4'b1110 && prev !== 4'b1110) found = 1;
            prev = an;
        end
        if (!found) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_digit0: an=%b never entered 1110", an);
        end
    endtask

    // Push the 4 expected digit slots for word w.
    task automatic push_word(input logic [15:0] w, input logic hist);
        exp_t e;
        logic [3:0] n;
        for (int d = 0; d < 4; d++) begin
            n     = w[d*4 +: 4];
            e.an  = ~(4'b0001 << d);
            e.seg = HEX[n];
            e.dp  = !(hist && d == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset_cpu = 1; data_in = 0; data_valid = 0; pc_in = 0;
        hold = 0; show_hist = 0; hist_sel = 0;
        tick(); tick();
        n_cmp++;
        if ({an, seg, dp, led, wwd_count} !== {4'b1111, 7'b1111111, 1'b1, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: an=%b seg=%b dp=%b led=%h cnt=%0d", an, seg, dp, led, wwd_count);
        end
        reset_cpu = 0;
        for (int k = 0; k < 5; k++) begin
            e.an = ~(4'b0001 << (k % 4)); e.seg = 7'b1000000; e.dp = 1'b1;
            exp_q.push_back(e);
        end
        for (int ed = 1; ed <= 17; ed++) begin
            tick();
            if (ed == 1) begin
                n_cmp++;
                if ({seg, dp, led, wwd_count} !== {7'b1000000, 1'b1, 8'd0, 8'd0}) begin
                    n_fail++;
                    $display("FAIL reset_edge1: seg=%b dp=%b led=%h cnt=%0d", seg, dp, led, wwd_count);
                end
            end
            if (ed == 4) begin
                n_cmp++;
                if (an !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL reset_slot_end: an=%b want 1110", an);
                end
            end
            if (ed % 4 == 1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (an !== e.an || seg !== e.seg) begin
                    n_fail++;
                    $display("FAIL reset_scan e%0d: an=%b seg=%b want an=%b seg=%b", ed, an, seg, e.an, e.seg);
                end
            end
        end
    endtask

    task automatic scan_check(input string name);
        exp_t e;
        wait_digit0();
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (4) tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                n_fail++;
                $display("FAIL %s d%0d: an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         name, d, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_capture();
        data_in = 16'h1A8F; data_valid = 1;
        tick();
        data_valid = 0;
        n_cmp++;
        if (wwd_count !== 8'd1) begin
            n_fail++;
            $display("FAIL capture_count: cnt=%0d want 1", wwd_count);
        end
        push_word(16'h1A8F, 1'b0);
        scan_check("capture_scan");
    endtask

    task automatic test_back_to_back();
        reset_cpu = 1; tick(); reset_cpu = 0;
        data_valid = 1;
        for (int v = 1; v <= 5; v++) begin
            data_in = 16'(v);
            tick();
        end
        data_valid = 0;
        n_cmp++;
        if (wwd_count !== 8'd5) begin
            n_fail++;
            $display("FAIL hist_count: cnt=%0d want 5", wwd_count);
        end
        show_hist = 1; hist_sel = 0;
        push_word(16'h0005, 1'b1);
        scan_check("hist_sel0");
        hist_sel = 3;
        push_word(16'h0002, 1'b1);
        scan_check("hist_sel3");
        hist_sel = 1;
        push_word(16'h0004, 1'b1);
        scan_check("hist_sel1");
        show_hist = 0; hist_sel = 0;
    endtask

    task automatic test_hold();
        logic [7:0] old, want;
        hold = 1; data_valid = 1; data_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            old = led;
            pc_in = 8'h30 + 8'(i * 17);
            led_q.push_back(pc_in);
            #1;
            n_cmp++;
            if (led !== old) begin
                n_fail++;
                $display("FAIL led_lag%0d: led=%h changed before edge, want %h", i, led, old);
            end
            tick();
            want = led_q.pop_front();
            n_cmp++;
            if (led !== want) begin
                n_fail++;
                $display("FAIL led_track%0d: led=%h want %h", i, led, want);
            end
        end
        data_valid = 0; hold = 0;
        n_cmp++;
        if (wwd_count !== 8'd5) begin
            n_fail++;
            $display("FAIL hold_count: cnt=%0d want 5", wwd_count);
        end
        push_word(16'h0005, 1'b0);
        scan_check("hold_capture");
        show_hist = 1; hist_sel = 0;
        push_word(16'h0005, 1'b1);
        scan_check("hold_hist");
        show_hist = 0;
    endtask

    task automatic test_saturation();
        data_valid = 1;
        for (int i = 1; i <= 300; i++) begin
            data_in = 16'(i);
            tick();
            if (i == 249 || i == 250 || i == 300) begin
                n_cmp++;
                if (wwd_count !== ((i == 249) ? 8'd254 : 8'd255)) begin
                    n_fail++;
                    $display("FAIL sat_%0d: cnt=%0d", i, wwd_count);
                end
            end
        end
        data_valid = 0;
    endtask

    task automatic test_reset_midscan();
        data_in = 16'hBEEF; data_valid = 1;
        tick();
        data_valid = 0;
        wait_digit0();
        repeat (8) tick();
        n_cmp++;
        if (an !== 4'b1011 || seg !== 7'b0000110) begin
            n_fail++;
            $display("FAIL midscan_pre: an=%b seg=%b want 1011 0000110", an, seg);
        end
        reset_cpu = 1; data_valid = 1; data_in = 16'h1234;
        tick();
        n_cmp++;
        if ({an, seg, dp, wwd_count} !== {4'b1111, 7'b1111111, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL midscan_reset: an=%b seg=%b dp=%b cnt=%0d", an, seg, dp, wwd_count);
        end
        reset_cpu = 0; data_valid = 0;
        tick();
        n_cmp++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL midscan_release: an=%b seg=%b want 1110 1000000", an, seg);
        end
        show_hist = 1;
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s);
            push_word(16'h0000, 1'b1);
            scan_check("midscan_hist");
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_back_to_back();
        test_hold();
        test_saturation();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wwd_display_driver.md
Name: wwd_display_driver

Overview:
- Sits directly downstream of the CPU core. Consumes its 16-bit output_port word and 8-bit PC low byte, and drives the board's 4-digit multiplexed 7-segment display and 8 LEDs.
- Captures each word presented by a WWD (write-word) strobe and keeps a 4-entry history of captured words.
- Scans the selected word onto the display as 4 hex digits using a refresh divider.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz digit rate at 50 MHz). Legal range is SCAN_DIV >= 2.

Ports:
- clk, input, 1: system clock, shared with the CPU.
- reset_cpu, input, 1: reset, synchronous, active-high. Same net as the CPU reset.
- data_in, input, 16: word from the CPU output_port.
- data_valid, input, 1: single-cycle strobe; data_in is valid this cycle.
- pc_in, input, 8: CPU PC_below8bit.
- hold, input, 1: freeze capture and history.
- show_hist, input, 1: 1 = display the history entry; 0 = display the live capture.
- hist_sel, input, 2: history index. 0 = most recent, 3 = oldest.
- seg, output, 7: segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- dp, output, 1: decimal point, active-low.
- an, output, 4: digit enables, active-low. an[0] is the rightmost digit.
- led, output, 8: registered copy of pc_in.
- wwd_count, output, 8: number of accepted captures, saturating.

Behaviour:
- Reset (reset_cpu=1 at a clk edge) clears all state at that edge:
  - seg=7'b1111111, dp=1, an=4'b1111, led=0, wwd_count=0.
  - Capture register = 0, all 4 history entries = 0, history write pointer = 0.
  - Divider counter = 0, digit index = 0.
- Reset asserted mid-scan or mid-capture wins over every other event in that cycle.
- Capture:
  - A strobe is accepted when data_valid=1 and hold=0, sampled at the clk edge.
  - On acceptance, at that edge:
    - capture <= data_in;
    - hist[wptr] <= data_in;
    - wptr <= wptr+1, mod 4, wrapping 3->0;
    - wwd_count <= wwd_count+1, saturating at 255 (stays 255).
  - data_valid=1 with hold=1 is ignored; no state changes.
  - Back-to-back strobes on consecutive cycles are each accepted.
- History read:
  - Entry k = hist[(wptr-1-hist_sel) mod 4].
  - Entries never written read 0.
- Display word:
  - disp = show_hist ? history entry : capture.
  - Combinational select from the registered state.
- Scan:
  - Divider counts 0..SCAN_DIV-1 and wraps to 0.
  - When the divider is at SCAN_DIV-1, the digit index increments mod 4 at the same edge.
  - Digit index i displays nibble disp[4i+3:4i].
- Outputs are registered, one cycle after the index/data they reflect:
  - an <= ~(4'b0001 << idx).
  - seg <= hex7(nibble).
  - dp <= 0 only when show_hist=1 and idx=0; otherwise 1.
  - First clk edge after reset release: an=1110, seg=hex7(0)=1000000.
  - A capture at edge N is visible on seg at edge N+1 for the currently scanned digit.
- hex7 table (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- led <= pc_in every cycle, independent of hold. Zero-latency pass-through is not allowed; led is always one cycle behind pc_in.
- Divider width is the minimum width for SCAN_DIV-1. No glitch or skipped digit at the wrap.

Test Plan:
1. Reset check, SCAN_DIV=4: assert reset_cpu for 2 cycles, then release -> at edge 1 an=1110, seg=1000000, dp=1, led=0, wwd_count=0. Digit index advances every 4 cycles: an sequence 1110, 1101, 1011, 0111, 1110.
2. Capture of data_in=16'h1A8F with data_valid for 1 cycle -> wwd_count=1. Over one scan the digits show F, 8, A, 1: seg 0001110, 0000000, 0001000, 1111001 with an 1110, 1101, 1011, 0111.
3. History wrap: strobe 5 words 0001, 0002, 0003, 0004, 0005 on back-to-back cycles, then show_hist=1:
   - hist_sel=0 shows 0005; hist_sel=3 shows 0002.
   - dp=0 only while an=1110.
   - wwd_count=5.
4. Hold: hold=1 with data_valid=1 and data_in=FFFF -> capture, history and wwd_count are unchanged; led still tracks pc_in with 1-cycle lag.
5. Saturation: 300 accepted strobes -> wwd_count reaches 255 and stays 255.
6. Reset mid-scan: assert reset_cpu while idx=2 and capture=BEEF -> next edge an=1111, seg=1111111. After release, digit 0 shows 0 and all history reads 0000.
